// File: rtl/alu_pipe.sv
// alu_pipe: handshaked 6502-family ALU with a one-entry registered result stage.
// Define K6502_DECIMAL_EN to build the extra BCD adjust cycle for decimal ADD/SUB.
module alu_pipe #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned NUM_ARGS = 8,
   parameter int unsigned SEL_W    = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                op,
   input  logic [SEL_W-1:0]          arg_sel,
   input  logic [NUM_ARGS*WIDTH-1:0] args,
   input  logic [WIDTH-1:0]          data_in,
   input  logic [7:0]                sr_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          data_out,
   output logic [7:0]                sr_out
);

   localparam int unsigned Msb = WIDTH - 1;
   localparam int unsigned SrC = 0;
   localparam int unsigned SrD = 3;

   localparam logic [3:0] OpAdd = 4'd0;
   localparam logic [3:0] OpSub = 4'd1;
   localparam logic [3:0] OpCmp = 4'd2;
   localparam logic [3:0] OpAnd = 4'd3;
   localparam logic [3:0] OpOr  = 4'd4;
   localparam logic [3:0] OpEor = 4'd5;
   localparam logic [3:0] OpInc = 4'd6;
   localparam logic [3:0] OpDec = 4'd7;
   localparam logic [3:0] OpAsl = 4'd8;
   localparam logic [3:0] OpLsr = 4'd9;
   localparam logic [3:0] OpRol = 4'd10;
   localparam logic [3:0] OpRor = 4'd11;
   localparam logic [3:0] OpTst = 4'd12;

   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      StIdle,
      StDone
`ifdef K6502_DECIMAL_EN
      , StAdj
`endif
   } state_e;

   state_e           state_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] data_q;
   logic [7:0]       sr_q;

   logic             accept;
   logic             cin;
   logic [WIDTH-1:0] a_op;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] bin_res;
   logic             bin_c;
   logic             bin_v;
   logic             unused_sr;

   assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
   assign accept    = in_valid & in_ready;
   assign cin       = sr_in[SrC];
   assign out_valid = out_valid_q;
   assign data_out  = data_q;
   assign sr_out    = sr_q;
   assign unused_sr = ^sr_in[7:1];

   always_comb begin
      a_op    = args[arg_sel*WIDTH +: WIDTH];
      sum     = '0;
      bin_res = '1;
      bin_c   = 1'b0;
      bin_v   = 1'b0;
      case (op)
         OpAdd: begin
            sum     = {1'b0, a_op} + {1'b0, data_in} + {{WIDTH{1'b0}}, cin};
            bin_res = sum[Msb:0];
            bin_c   = sum[WIDTH];
            bin_v   = (a_op[Msb] == data_in[Msb]) && (bin_res[Msb] != a_op[Msb]);
         end
         // Subtract as A + ~B + carry-in; CMP forces carry-in so C reads as A>=B.
         OpSub, OpCmp: begin
            sum     = {1'b0, a_op} + {1'b0, ~data_in} + {{WIDTH{1'b0}}, (op == OpCmp) | cin};
            bin_res = sum[Msb:0];
            bin_c   = sum[WIDTH];
            bin_v   = (op == OpSub) && (a_op[Msb] != data_in[Msb]) && (bin_res[Msb] != a_op[Msb]);
         end
         OpAnd: bin_res = a_op & data_in;
         OpOr:  bin_res = a_op | data_in;
         OpEor: bin_res = a_op ^ data_in;
         OpInc: bin_res = a_op + One;
         OpDec: bin_res = a_op - One;
         OpAsl: begin bin_res = {a_op[Msb-1:0], 1'b0}; bin_c = a_op[Msb]; end
         OpLsr: begin bin_res = {1'b0, a_op[Msb:1]};   bin_c = a_op[0];   end
         OpRol: begin bin_res = {a_op[Msb-1:0], cin};  bin_c = a_op[Msb]; end
         OpRor: begin bin_res = {cin, a_op[Msb:1]};    bin_c = a_op[0];   end
         OpTst: bin_res = a_op;
         default: ;
      endcase
   end

`ifdef K6502_DECIMAL_EN
   logic [WIDTH-1:0] a_q, b_q;
   logic             cin_q, sub_q;
   logic [WIDTH:0]   adj;
   logic             dec_op;

   // Nibble-serial decimal add/sub; returns {carry (not-borrow for sub), result}.
   function automatic logic [WIDTH:0] bcd_adj(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic ci, input logic sub);
      logic [4:0]       nib;
      logic             c;
      logic [WIDTH-1:0] r;
      c = sub ? ~ci : ci;
      r = '0;
      for (int i = 0; i < int'(WIDTH / 4); i++) begin
         if (!sub) begin
            nib = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            c   = (nib > 5'd9);
            if (c) nib = nib + 5'd6;
         end else begin
            nib = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, c};
            c   = nib[4];
            if (c) nib = nib - 5'd6;
         end
         r[4*i +: 4] = nib[3:0];
      end
      return {sub ? ~c : c, r};
   endfunction

   assign dec_op = ((op == OpAdd) || (op == OpSub)) && sr_in[SrD];
   assign adj    = bcd_adj(a_q, b_q, cin_q, sub_q);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         sr_q        <= '0;
`ifdef K6502_DECIMAL_EN
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         sub_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
`ifdef K6502_DECIMAL_EN
            StAdj: begin
               data_q      <= adj[Msb:0];
               sr_q        <= {adj[Msb], sr_q[6], 4'b0000, ~|adj[Msb:0], adj[WIDTH]};
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end
`endif
            default: begin
               if (accept) begin
                  data_q      <= bin_res;
                  sr_q        <= {bin_res[Msb], bin_v, 4'b0000, ~|bin_res, bin_c};
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
`ifdef K6502_DECIMAL_EN
                  a_q   <= a_op;
                  b_q   <= data_in;
                  cin_q <= cin;
                  sub_q <= (op == OpSub);
                  // Binary V is kept in sr_q; the result stays hidden until adjusted.
                  if (dec_op) begin
                     out_valid_q <= 1'b0;
                     state_q     <= StAdj;
                  end
`endif
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized self-checking bench for alu_pipe against an integer reference model.
// Decimal expectations follow K6502_DECIMAL_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_alu_pipe;

   localparam int OpAdd = 0, OpSub = 1, OpCmp = 2, OpAnd = 3, OpOr = 4, OpEor = 5, OpInc = 6;
   localparam int OpDec = 7, OpAsl = 8, OpLsr = 9, OpRol = 10, OpRor = 11, OpTst = 12;
`ifdef K6502_DECIMAL_EN
   localparam bit DecBuilt = 1'b1;
`else
   localparam bit DecBuilt = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        iv8, ir8, ov8, or8;
   logic [3:0]  op8;
   logic [2:0]  sel8;
   logic [63:0] args8;
   logic [7:0]  din8, sr8, dout8, srout8;

   logic        iv16, ir16, ov16, or16;
   logic [3:0]  op16;
   logic [1:0]  sel16;
   logic [63:0] args16;
   logic [15:0] din16, dout16;
   logic [7:0]  sr16, srout16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8), .NUM_ARGS(8), .SEL_W(3)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8), .arg_sel(sel8),
      .args(args8), .data_in(din8), .sr_in(sr8), .out_valid(ov8), .out_ready(or8),
      .data_out(dout8), .sr_out(srout8)
   );

   alu_pipe #(.WIDTH(16), .NUM_ARGS(4), .SEL_W(2)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16), .arg_sel(sel16),
      .args(args16), .data_in(din16), .sr_in(sr16), .out_valid(ov16), .out_ready(or16),
      .data_out(dout16), .sr_out(srout16)
   );

   // Reference: plain integer arithmetic on unsigned/signed views of the operands.
   function automatic void model(input int w, input int op, input int a, input int b,
                                 input bit ci, input bit d, output int r, output logic [7:0] sr);
      int m, h, s, sa, sb, ss, carry, t, res, da, db;
      bit c, v;
      m = 1 << w;
      h = m / 2;
      c = 1'b0;
      v = 1'b0;
      sa = (a >= h) ? a - m : a;
      sb = (b >= h) ? b - m : b;
      case (op)
         OpAdd: begin
            s = a + b + int'(ci); r = s % m; c = (s >= m);
            ss = sa + sb + int'(ci); v = (ss >= h) || (ss < -h);
         end
         OpSub: begin
            s = a - b - (1 - int'(ci)); r = (s + m) % m; c = (s >= 0);
            ss = sa - sb - (1 - int'(ci)); v = (ss >= h) || (ss < -h);
         end
         OpCmp: begin r = (a - b + m) % m; c = (a >= b); end
         OpAnd: r = a & b;
         OpOr:  r = a | b;
         OpEor: r = a ^ b;
         OpInc: r = (a + 1) % m;
         OpDec: r = (a + m - 1) % m;
         OpAsl: begin r = (a * 2) % m; c = (a >= h); end
         OpLsr: begin r = a / 2; c = (a % 2 == 1); end
         OpRol: begin r = (a * 2) % m + int'(ci); c = (a >= h); end
         OpRor: begin r = a / 2 + (ci ? h : 0); c = (a % 2 == 1); end
         OpTst: r = a;
         default: r = m - 1;
      endcase
      if (DecBuilt && d && (op == OpAdd || op == OpSub)) begin
         res = 0;
         carry = (op == OpAdd) ? int'(ci) : 1 - int'(ci);
         for (int i = 0; i < w / 4; i++) begin
            da = (a >> (4 * i)) % 16;
            db = (b >> (4 * i)) % 16;
            if (op == OpAdd) begin
               t = da + db + carry; carry = (t > 9) ? 1 : 0; if (carry == 1) t = t + 6;
            end else begin
               t = da - db - carry; carry = (t < 0) ? 1 : 0; if (carry == 1) t = t - 6;
            end
            res = res + (((t + 32) % 16) << (4 * i));
         end
         r = res;
         c = (op == OpAdd) ? (carry == 1) : (carry == 0);
      end
      sr = {r >= h, v, 4'b0000, r == 0, c};
   endfunction

   task automatic run8(input int op, input int a, input int b, input bit ci, input bit d,
                       input string name);
      int r, lat, lat_exp;
      logic [7:0] sr_exp;
      model(8, op, a, b, ci, d, r, sr_exp);
      lat_exp = (DecBuilt && d && op <= OpSub) ? 2 : 1;
      @(negedge clk);
      sel8 = 3'($urandom_range(0, 7));
      args8 = {$urandom, $urandom};
      args8[sel8*8 +: 8] = 8'(a);
      op8 = 4'(op); din8 = 8'(b);
      sr8 = 8'($urandom); sr8[0] = ci; sr8[3] = d;
      iv8 = 1'b1; or8 = 1'b0;
      @(posedge clk); #1 iv8 = 1'b0;
      lat = 1;
      while (!ov8 && lat < 8) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== lat_exp) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, lat_exp); end
      checks++;
      if (dout8 !== 8'(r)) begin errors++; $display("FAIL %s data got %h want %h", name, dout8, 8'(r)); end
      checks++;
      if (srout8 !== sr_exp) begin errors++; $display("FAIL %s sr got %h want %h", name, srout8, sr_exp); end
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1 or8 = 1'b0;
   endtask

   task automatic run16(input int op, input int a, input int b, input bit ci, input bit d,
                        input int sel, input string name);
      int r, lat, lat_exp;
      logic [7:0] sr_exp;
      model(16, op, a, b, ci, d, r, sr_exp);
      lat_exp = (DecBuilt && d && op <= OpSub) ? 2 : 1;
      @(negedge clk);
      sel16 = (sel < 0) ? 2'($urandom_range(0, 3)) : 2'(sel);
      args16 = {$urandom, $urandom};
      args16[sel16*16 +: 16] = 16'(a);
      op16 = 4'(op); din16 = 16'(b);
      sr16 = 8'($urandom); sr16[0] = ci; sr16[3] = d;
      iv16 = 1'b1; or16 = 1'b0;
      @(posedge clk); #1 iv16 = 1'b0;
      lat = 1;
      while (!ov16 && lat < 8) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== lat_exp) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, lat_exp); end
      checks++;
      if (dout16 !== 16'(r)) begin errors++; $display("FAIL %s data got %h want %h", name, dout16, 16'(r)); end
      checks++;
      if (srout16 !== sr_exp) begin errors++; $display("FAIL %s sr got %h want %h", name, srout16, sr_exp); end
      @(negedge clk); or16 = 1'b1;
      @(posedge clk); #1 or16 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ov8 !== 1'b0 || ov16 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0/0", ov8, ov16); end
      checks++;
      if (dout8 !== 8'h00 || srout8 !== 8'h00) begin errors++; $display("FAIL reset_data got %h/%h want 00/00", dout8, srout8); end
      checks++;
      if (dout16 !== 16'h0 || srout16 !== 8'h00) begin errors++; $display("FAIL reset_data16 got %h/%h want 0/0", dout16, srout16); end
      @(negedge clk); rst_n = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1 || ir16 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b want 1/1", ir8, ir16); end
   endtask

   task automatic test_directed();
      run8(OpAdd, 'h50, 'h50, 1'b0, 1'b0, "add_ovf");
      run8(OpSub, 'h00, 'h01, 1'b1, 1'b0, "sub_borrow");
      run8(OpCmp, 'h40, 'h40, 1'b0, 1'b0, "cmp_eq");
      run8(OpAdd, 'h19, 'h28, 1'b0, 1'b1, "dec_add");
      run8(OpAdd, 'h99, 'h01, 1'b0, 1'b1, "dec_carry");
      run8(OpSub, 'h42, 'h13, 1'b1, 1'b1, "dec_sub");
      run8(14, 'h12, 'h34, 1'b1, 1'b0, "unknown_op");
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++)
         run8($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
              1'($urandom), 1'($urandom), "rand8");
   endtask

   task automatic test_backpressure();
      int r1, r2;
      logic [7:0] s1, s2;
      model(8, OpAdd, 'h3C, 'h4D, 1'b1, 1'b0, r1, s1);
      model(8, OpEor, 'hA5, 'h0F, 1'b0, 1'b0, r2, s2);
      @(negedge clk);
      sel8 = 3'd5; args8 = {$urandom, $urandom}; args8[5*8 +: 8] = 8'h3C;
      op8 = 4'(OpAdd); din8 = 8'h4D; sr8 = 8'h01; iv8 = 1'b1; or8 = 1'b0;
      @(posedge clk); #1 iv8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ov8 !== 1'b1 || ir8 !== 1'b0) begin errors++; $display("FAIL hold_flow got v=%b r=%b want v=1 r=0", ov8, ir8); end
         checks++;
         if (dout8 !== 8'(r1) || srout8 !== s1) begin errors++; $display("FAIL hold_data got %h/%h want %h/%h", dout8, srout8, 8'(r1), s1); end
      end
      @(negedge clk);
      or8 = 1'b1; iv8 = 1'b1; sel8 = 3'd2; args8[2*8 +: 8] = 8'hA5;
      op8 = 4'(OpEor); din8 = 8'h0F; sr8 = 8'h00;
      #1;
      checks++;
      if (ir8 !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", ir8); end
      @(posedge clk); #1 iv8 = 1'b0; or8 = 1'b0;
      checks++;
      if (ov8 !== 1'b1 || dout8 !== 8'(r2) || srout8 !== s2) begin
         errors++; $display("FAIL release_next got v=%b %h/%h want v=1 %h/%h", ov8, dout8, srout8, 8'(r2), s2);
      end
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1 or8 = 1'b0;
   endtask

   task automatic test_back_to_back();
      int q_d[$];
      logic [7:0] q_sr[$];
      int n, sent, got, stalls, exp_stalls, cyc, op, a, b, r, e;
      bit pending, ci, d;
      logic [7:0] s, es;
      n = 120; sent = 0; got = 0; stalls = 0; exp_stalls = 0; cyc = 0; pending = 1'b0;
      op = 0; a = 0; b = 0; ci = 1'b0; d = 1'b0;
      @(negedge clk); or8 = 1'b1;
      while ((sent < n || got < n) && cyc < 10 * n) begin
         @(negedge clk); cyc++;
         if (ov8) begin
            checks++;
            if (q_d.size() == 0) begin
               errors++; $display("FAIL stream_extra got %h want none", dout8);
            end else begin
               e = q_d.pop_front(); es = q_sr.pop_front(); got++;
               if (dout8 !== 8'(e) || srout8 !== es) begin
                  errors++; $display("FAIL stream_data got %h/%h want %h/%h", dout8, srout8, 8'(e), es);
               end
            end
         end
         if (sent < n) begin
            if (!pending) begin
               op = $urandom_range(0, 15); a = $urandom_range(0, 255); b = $urandom_range(0, 255);
               ci = 1'($urandom); d = 1'($urandom);
               sel8 = 3'($urandom_range(0, 7)); args8 = {$urandom, $urandom};
               args8[sel8*8 +: 8] = 8'(a);
               op8 = 4'(op); din8 = 8'(b); sr8 = 8'($urandom); sr8[0] = ci; sr8[3] = d;
               pending = 1'b1;
            end
            iv8 = 1'b1;
            #1;
            if (ir8) begin
               model(8, op, a, b, ci, d, r, s);
               q_d.push_back(r); q_sr.push_back(s);
               sent++; pending = 1'b0;
               if (DecBuilt && d && op <= OpSub && sent < n) exp_stalls++;
            end else stalls++;
         end else iv8 = 1'b0;
      end
      iv8 = 1'b0; or8 = 1'b0;
      checks++;
      if (got !== n || q_d.size() !== 0) begin errors++; $display("FAIL stream_count got %0d want %0d", got, n); end
      checks++;
      if (stalls !== exp_stalls) begin errors++; $display("FAIL stream_stalls got %0d want %0d", stalls, exp_stalls); end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      sel8 = 3'd1; args8 = {$urandom, $urandom}; args8[1*8 +: 8] = 8'h19;
      op8 = 4'(OpAdd); din8 = 8'h28; sr8 = 8'h08; iv8 = 1'b1; or8 = 1'b0;
      @(posedge clk); #1 iv8 = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ov8 !== 1'b0 || dout8 !== 8'h00) begin errors++; $display("FAIL midop_reset got v=%b d=%h want v=0 d=00", ov8, dout8); end
      @(negedge clk); rst_n = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1) begin errors++; $display("FAIL midop_ready got %b want 1", ir8); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ov8 !== 1'b0) begin errors++; $display("FAIL midop_stale got %b want 0", ov8); end
      end
   endtask

   task automatic test_w16();
      run16(OpInc, 'hFFFF, 'h1234, 1'b0, 1'b0, 3, "inc16_wrap");
      run16(OpRor, 'h0001, 'h0000, 1'b1, 1'b0, -1, "ror16");
      for (int i = 0; i < 40; i++)
         run16($urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 65535),
               1'($urandom), 1'($urandom), -1, "rand16");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      iv8 = 1'b0; or8 = 1'b0; op8 = '0; sel8 = '0; args8 = '0; din8 = '0; sr8 = '0;
      iv16 = 1'b0; or16 = 1'b0; op16 = '0; sel16 = '0; args16 = '0; din16 = '0; sr16 = '0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_w16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
